// File: rtl/hidden_cpu_core.sv
// hidden_cpu_core
//   Register CPU core fed one instruction per clock directly from the host (no fetch).
//   Holds an NREGS x DW register file, a DW-bit pc, carry/borrow flags, an output
//   select bit and a RUN/HALT state. All state updates on the rising edge of clk.
//
// Ports
//   clk          clock
//   rst          synchronous, active-high reset
//   instrValid   -> instr_valid: execute instr this cycle when 1 (ignored in HALT)
//   instr        {op[2:0], rd[AW-1:0], rs[AW-1:0]}
//   out_data     out_sel ? r[NREGS-1] : pc
//   pc_o         current pc
//   carry_o      carry flag (set by ADD)
//   borrow_o     borrow flag (set by SUB)
//   halted       core is in HALT
module hidden_cpu_core #(
  parameter int DW    = 8,
  parameter int NREGS = 4,
  localparam int AW   = $clog2(NREGS),
  localparam int IW   = 3 + 2*AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  input  logic [IW-1:0] instr,
  output logic [DW-1:0] out_data,
  output logic [DW-1:0] pc_o,
  output logic          carry_o,
  output logic          borrow_o,
  output logic          halted
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MOV = 3'b100;
  localparam logic [2:0] OP_BR  = 3'b101;
  localparam logic [2:0] OP_TOG = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  typedef enum logic {sRun = 1'b0, sHalt = 1'b1} state_t;

  state_t                        state;
  logic [NREGS-1:0][DW-1:0]      regFile;
  logic [DW-1:0]                 pc;
  logic                          carry;
  logic                          borrow;
  logic                          outSel;

  // Instruction fields
  logic [2:0]    op;
  logic [AW-1:0] rd;
  logic [AW-1:0] rs;
  assign op = instr[IW-1 -: 3];
  assign rd = instr[2*AW-1 -: AW];
  assign rs = instr[AW-1:0];

  // Operands are the pre-edge register values; rd==rs simply reads the same entry twice.
  logic [DW-1:0] rdVal;
  logic [DW-1:0] rsVal;
  logic [DW:0]   sum;
  logic [DW-1:0] diff;
  logic [DW-1:0] pcInc;
  logic [DW-1:0] brTarget;
  logic          brTaken;

  assign rdVal    = regFile[rd];
  assign rsVal    = regFile[rs];
  assign sum      = {1'b0, rdVal} + {1'b0, rsVal};
  assign diff     = rdVal - rsVal;
  assign pcInc    = pc + 1'b1;
  // Branch offset is the last register; a zero offset makes a legal spin loop.
  assign brTarget = pc + regFile[NREGS-1];

  always_comb begin
    brTaken = 1'b0;
    case (rs[1:0])
      2'b00:   brTaken = 1'b1;
      2'b01:   brTaken = carry;
      2'b10:   brTaken = borrow;
      default: brTaken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= sRun;
      pc     <= '0;
      carry  <= 1'b0;
      borrow <= 1'b0;
      outSel <= 1'b0;
      for (int i = 0; i < NREGS; i++) regFile[i] <= DW'(i);
    end else if (state == sRun && instr_valid) begin
      case (op)
        OP_ADD: begin
          regFile[rd] <= sum[DW-1:0];
          carry       <= sum[DW];
          pc          <= pcInc;
        end
        OP_SUB: begin
          regFile[rd] <= diff;
          borrow      <= (rsVal > rdVal);
          pc          <= pcInc;
        end
        OP_AND: begin
          regFile[rd] <= rdVal & rsVal;
          pc          <= pcInc;
        end
        OP_XOR: begin
          regFile[rd] <= rdVal ^ rsVal;
          pc          <= pcInc;
        end
        OP_MOV: begin
          regFile[rd] <= rsVal;
          pc          <= pcInc;
        end
        OP_BR: begin
          pc <= brTaken ? brTarget : pcInc;
        end
        OP_TOG: begin
          outSel <= ~outSel;
          pc     <= pcInc;
        end
        OP_HLT: begin
          // pc, registers and flags freeze from here until reset
          state <= sHalt;
        end
        default: ;
      endcase
    end
  end

  assign out_data = outSel ? regFile[NREGS-1] : pc;
  assign pc_o     = pc;
  assign carry_o  = carry;
  assign borrow_o = borrow;
  assign halted   = (state == sHalt);

endmodule
